io_interval_timer: RTL and testbench
====================================

IO_INTERVAL_TIMER -- requirements
Module: io_interval_timer

Interface
REQ-001 SHALL have parameter DEVNUM, default 7'o020, the I/O device number this block answers to.
REQ-002 SHALL have parameter PRESCALE, default 100, the clock cycles per timer tick (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port io_dev, input, `DEVICE (7 bits): the addressed device.
REQ-006 SHALL have port io_cond, input, 1 bit: 1 selects CONI/CONO, 0 selects DATAI/DATAO.
REQ-007 SHALL have port io_read, input, 1 bit: read request (CONI/DATAI).
REQ-008 SHALL have port io_write, input, 1 bit: write request (CONO/DATAO).
REQ-009 SHALL have port io_write_data, input, `WORD (36 bits): write data.
REQ-010 SHALL have port io_read_data, output, `WORD: read data.
REQ-011 SHALL have port io_read_ack, output, 1 bit: read complete.
REQ-012 SHALL have port io_write_ack, output, 1 bit: write complete.
REQ-013 SHALL have port io_nxd, output, 1 bit: request is addressed to a different device.
REQ-014 SHALL have port io_pi, output, [1:7]: priority interrupt request, one bit per level.

Function
REQ-015 Handshake: the initiator holds io_read or io_write, with io_dev, io_cond and io_write_data stable, until it sees an ack or nxd.
REQ-016 The block SHALL never see io_read and io_write asserted together; if it does, it treats the pair as a write.
REQ-017 On a matching request, the ack SHALL rise exactly 1 cycle after the request is first sampled.
REQ-018 The ack SHALL stay high while the request is held, and SHALL drop on the cycle after the request drops.
REQ-019 A write SHALL take effect exactly once per request, on the first sampled cycle, never again while the request is held.
REQ-020 Read data SHALL be registered, valid whenever io_read_ack is high, and SHALL be 0 otherwise.
REQ-021 On a non-matching io_dev, io_nxd SHALL rise 1 cycle after the request is sampled, with no ack, and SHALL drop 1 cycle after the request drops.
REQ-022 CONO SHALL decode bits 33-35 as PI level, 32 as ENABLE and 31 as CLEAR_DONE (also clears OVERRUN).
REQ-023 CONO bits 33-35 and 32 SHALL be loaded unconditionally; all other CONO bits are ignored.
REQ-024 CONI SHALL return 0 in bits 0-29, OVERRUN in 30, DONE in 31, ENABLE in 32 and PI level in 33-35.
REQ-025 DATAO SHALL load the interval register from bits 18-35 and also load the counter with the same value.
REQ-026 DATAO SHALL reset the prescaler to 0.
REQ-027 DATAI SHALL return the live 18-bit counter in bits 18-35, with bits 0-17 = 0.
REQ-028 While ENABLE=1 and the interval is nonzero, the prescaler SHALL count 0..PRESCALE-1 and emit a one-cycle tick on wrap.
REQ-029 Each tick SHALL decrement the counter; the counter SHALL not wrap through 0.
REQ-030 A tick with counter=1 (expiry) SHALL set the counter to the interval and set DONE.
REQ-031 If DONE is already set at expiry, the expiry SHALL also set OVERRUN.
REQ-032 Interval=0 SHALL halt counting, with no ticks and no expiry.
REQ-033 ENABLE=0 SHALL freeze the prescaler and counter; re-enabling SHALL resume from the frozen values.
REQ-034 io_pi[L] SHALL be asserted (registered) while DONE=1 and PI level L is nonzero; all io_pi bits are 0 otherwise.
REQ-035 Simultaneous CONO CLEAR_DONE and expiry: the expiry wins, and DONE ends the cycle set.
REQ-036 Simultaneous DATAO and tick or expiry: DATAO wins, with no decrement and no DONE.
REQ-037 A counter or status read on the same cycle as an update SHALL return the pre-update value.

Reset
REQ-038 Reset SHALL clear the interval, counter, prescaler, DONE, OVERRUN, ENABLE and PI level.
REQ-039 Reset SHALL force io_read_data=0, io_read_ack=0, io_write_ack=0, io_nxd=0 and io_pi=0 from the next edge.
REQ-040 Reset mid-transaction SHALL abort it; after reset the block treats a still-held request as new.

Structure
REQ-041 The default device number, the CONI/CONO bit positions and the counter width (18) SHALL live in constants.svh.
REQ-042 The prescaler SHALL be one sub-module, io_prescaler (inputs clk, reset, enable, clear; output tick).
REQ-043 The handshake, registers and PI logic SHALL stay in io_interval_timer.

Verification
REQ-044 Non-matching device: CONI to dev 7'o021 -> io_nxd high 1 cycle later, no ack, no state change.
REQ-045 Basic expiry: PRESCALE=4, DATAO 5, then CONO 0o15 (ENABLE, PI level 5) -> DONE set and io_pi=7'b0000100 after 20 cycles; DATAI then returns 5.
REQ-046 Overrun: continue REQ-045 without clearing -> OVERRUN set at the second expiry; CONI returns 0o000000000035 | bit30.
REQ-047 Clear versus expiry: CONO CLEAR_DONE on the expiry cycle -> DONE remains 1; a repeat CONO 0o35 clears DONE and OVERRUN, and io_pi goes to 0 next cycle.
REQ-048 Held request: hold io_write for 10 cycles with DATAO 3 -> ack high cycles 1-10, the counter is loaded once, and the ack drops 1 cycle after the request drops.
REQ-049 Reset mid-read: reset during an acked DATAI -> all outputs 0 next cycle; with io_read still held after reset, a fresh ack arrives 1 cycle after reset deasserts.

Source files
------------

// File: rtl/io_interval_timer_pkg.sv
// Types, vector indices and the PI decode helper shared by the interval timer,
// its bus interface and its prescaler.
`include "constants.svh"

package io_interval_timer_pkg;

  localparam int WORD_W    = `WORD_W;
  localparam int COUNTER_W = `COUNTER_W;

  // Vector indices of the PDP-10 numbered status/control fields.
  localparam int OVERRUN_IX  = WORD_W - 1 - `CONI_OVERRUN_BIT;
  localparam int DONE_IX     = WORD_W - 1 - `CONI_DONE_BIT;
  localparam int CLEAR_IX    = WORD_W - 1 - `CONO_CLEAR_DONE_BIT;
  localparam int ENABLE_IX   = WORD_W - 1 - `CON_ENABLE_BIT;
  localparam int LEVEL_IX    = WORD_W - 1 - `CON_PI_LEVEL_LSB;
  localparam int LEVEL_W     = `CON_PI_LEVEL_LSB - `CON_PI_LEVEL_MSB + 1;
  localparam int DATA_LSB_IX = WORD_W - 1 - (`DATA_FIRST_BIT + COUNTER_W - 1);

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [6:0]           device_t;
  typedef logic [COUNTER_W-1:0] counter_t;
  typedef logic [LEVEL_W-1:0]   pi_level_t;
  typedef logic [1:7]           pi_bus_t;

  typedef struct packed {
    logic      overrun;
    logic      done;
    logic      enable;
    pi_level_t level;
  } status_t;

  function automatic pi_bus_t pi_decode(input logic done, input pi_level_t level);
    pi_bus_t pi;
    for (int l = 1; l <= 7; l++) begin
      pi[l] = done && (level == pi_level_t'(l));
    end
    return pi;
  endfunction

endpackage

// File: rtl/io_interval_timer_if.sv
// I/O bus bundle between an initiator (master) and a device such as the interval timer (slave).
interface io_interval_timer_if;
  import io_interval_timer_pkg::*;

  device_t dev;
  logic    cond;
  logic    read;
  logic    write;
  word_t   write_data;
  word_t   read_data;
  logic    read_ack;
  logic    write_ack;
  logic    nxd;
  pi_bus_t pi;

  modport master (
    output dev, cond, read, write, write_data,
    input  read_data, read_ack, write_ack, nxd, pi
  );

  modport slave (
    input  dev, cond, read, write, write_data,
    output read_data, read_ack, write_ack, nxd, pi
  );
endinterface

// File: rtl/constants.svh
// Shared constants for the interval timer: bus widths, the default device number
// and PDP-10 style bit positions, where bit 0 is the MSB and bit 35 the LSB.
`ifndef IO_INTERVAL_TIMER_CONSTANTS_SVH
`define IO_INTERVAL_TIMER_CONSTANTS_SVH

`define WORD   [35:0]
`define DEVICE [6:0]

`define WORD_W         36
`define COUNTER_W      18
`define DEVNUM_DEFAULT 7'o020

`define CONI_OVERRUN_BIT    30
`define CONI_DONE_BIT       31
`define CONO_CLEAR_DONE_BIT 31
`define CON_ENABLE_BIT      32
`define CON_PI_LEVEL_MSB    33
`define CON_PI_LEVEL_LSB    35
`define DATA_FIRST_BIT      18

`endif

// File: rtl/io_prescaler.sv
// Divides clk by PRESCALE: counts 0..PRESCALE-1 while enabled and flags the wrap cycle.
module io_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;

  // A clear (interval reload) suppresses the wrap so the reload wins over a tick.
  assign tick = enable && !clear && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/io_interval_timer.sv
// Interval timer I/O device: DATAO/DATAI reach the 18-bit interval counter, CONO/CONI
// the ENABLE/DONE/OVERRUN/PI-level status; DONE raises a priority interrupt request.
`include "constants.svh"

module io_interval_timer
  import io_interval_timer_pkg::*;
#(
  parameter logic `DEVICE DEVNUM   = `DEVNUM_DEFAULT,
  parameter int           PRESCALE = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic `DEVICE io_dev,
  input  logic         io_cond,
  input  logic         io_read,
  input  logic         io_write,
  input  logic `WORD   io_write_data,
  output logic `WORD   io_read_data,
  output logic         io_read_ack,
  output logic         io_write_ack,
  output logic         io_nxd,
  output pi_bus_t      io_pi
);
  logic     w_req, w_match, w_is_wr, w_is_rd, w_first;
  logic     w_datao, w_cono, w_tick, w_expire, w_presc_en;
  logic     w_unused_wdata;
  counter_t r_interval, r_counter, w_interval_nxt, w_counter_nxt;
  status_t  r_status, w_status_nxt;
  logic     r_req_seen;
  word_t    w_coni, w_datai;
  word_t    r_read_data;
  logic     r_read_ack, r_write_ack, r_nxd;
  pi_bus_t  r_pi;

  // A simultaneous read and write is treated as a write.
  assign w_req   = io_read | io_write;
  assign w_is_wr = io_write;
  assign w_is_rd = io_read & ~io_write;
  assign w_match = (io_dev == DEVNUM);
  assign w_first = w_req & ~r_req_seen;
  assign w_datao = w_first & w_is_wr & w_match & ~io_cond;
  assign w_cono  = w_first & w_is_wr & w_match & io_cond;

  assign w_presc_en = r_status.enable && (r_interval != '0);
  assign w_expire   = w_tick && (r_counter == counter_t'(1));
  assign w_unused_wdata = ^io_write_data[WORD_W-1:DATA_LSB_IX+COUNTER_W];

  io_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (w_presc_en),
    .clear  (w_datao),
    .tick   (w_tick)
  );

  always_comb begin
    w_coni                            = '0;
    w_coni[OVERRUN_IX]                = r_status.overrun;
    w_coni[DONE_IX]                   = r_status.done;
    w_coni[ENABLE_IX]                 = r_status.enable;
    w_coni[LEVEL_IX +: LEVEL_W]       = r_status.level;
    w_datai                           = '0;
    w_datai[DATA_LSB_IX +: COUNTER_W] = r_counter;
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_interval_nxt = r_interval;
    w_counter_nxt  = r_counter;
    w_status_nxt   = r_status;

    if (w_datao) begin
      w_interval_nxt = io_write_data[DATA_LSB_IX +: COUNTER_W];
      w_counter_nxt  = io_write_data[DATA_LSB_IX +: COUNTER_W];
    end else if (w_tick) begin
      if (r_counter == counter_t'(1)) w_counter_nxt = r_interval;
      else if (r_counter != '0)       w_counter_nxt = r_counter - 1'b1;
    end

    if (w_cono) begin
      w_status_nxt.enable = io_write_data[ENABLE_IX];
      w_status_nxt.level  = io_write_data[LEVEL_IX +: LEVEL_W];
      if (io_write_data[CLEAR_IX]) begin
        w_status_nxt.done    = 1'b0;
        w_status_nxt.overrun = 1'b0;
      end
    end

    // Expiry is applied last so it overrides a clear arriving on the same cycle.
    if (w_expire) begin
      w_status_nxt.done = 1'b1;
      if (r_status.done) w_status_nxt.overrun = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop updates from the same pre-edge values.
    if (reset) begin
      r_req_seen  <= 1'b0;
      r_interval  <= '0;
      r_counter   <= '0;
      r_status    <= '0;
      r_read_data <= '0;
      r_read_ack  <= 1'b0;
      r_write_ack <= 1'b0;
      r_nxd       <= 1'b0;
      r_pi        <= '0;
    end else begin
      r_req_seen  <= w_req;
      r_interval  <= w_interval_nxt;
      r_counter   <= w_counter_nxt;
      r_status    <= w_status_nxt;
      r_read_ack  <= w_is_rd & w_match;
      r_write_ack <= w_is_wr & w_match;
      r_nxd       <= w_req & ~w_match;
      r_read_data <= (w_is_rd & w_match) ? (io_cond ? w_coni : w_datai) : '0;
      r_pi        <= pi_decode(w_status_nxt.done, w_status_nxt.level);
    end
  end

  assign io_read_data = r_read_data;
  assign io_read_ack  = r_read_ack;
  assign io_write_ack = r_write_ack;
  assign io_nxd       = r_nxd;
  assign io_pi        = r_pi;
endmodule

// File: tb/tb_io_interval_timer.sv
// Bench for io_interval_timer: an arithmetic reference model checked every cycle,
// plus directed transactions with hand-computed expectations.
module tb_io_interval_timer;

  localparam int          PRESCALE = 4;
  localparam logic [6:0]  DEV      = 7'o020;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_on  = 0;

  io_interval_timer_if bus ();

  io_interval_timer #(.DEVNUM(DEV), .PRESCALE(PRESCALE)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_dev        (bus.dev),
    .io_cond       (bus.cond),
    .io_read       (bus.read),
    .io_write      (bus.write),
    .io_write_data (bus.write_data),
    .io_read_data  (bus.read_data),
    .io_read_ack   (bus.read_ack),
    .io_write_ack  (bus.write_ack),
    .io_nxd        (bus.nxd),
    .io_pi         (bus.pi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the counter value is derived from the number of enabled cycles since the last load.
  int unsigned m_run;
  logic [17:0] m_interval;
  logic        m_done, m_ovr, m_en, m_seen;
  logic [2:0]  m_lvl;
  logic        e_rack, e_wack, e_nxd;
  logic [35:0] e_rdata;
  logic [1:7]  e_pi;
  logic        t_req, t_wr, t_rd, t_hit, t_first, t_old_done, t_expire;
  logic [35:0] t_coni, t_datai;

  function automatic logic [17:0] m_counter();
    if (m_interval == 18'd0) return 18'd0;
    return m_interval - 18'((m_run / PRESCALE) % m_interval);
  endfunction

  initial begin
    m_run = 0; m_interval = 0; m_done = 0; m_ovr = 0; m_en = 0; m_seen = 0; m_lvl = 0;
    e_rack = 0; e_wack = 0; e_nxd = 0; e_rdata = 0; e_pi = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_interval = 0; m_done = 0; m_ovr = 0; m_en = 0; m_seen = 0; m_lvl = 0;
      e_rack = 0; e_wack = 0; e_nxd = 0; e_rdata = 0; e_pi = 0;
    end else begin
      t_req   = bus.read | bus.write;
      t_wr    = bus.write;
      t_rd    = bus.read & ~bus.write;
      t_hit   = (bus.dev == DEV);
      t_first = t_req & ~m_seen;
      t_coni  = 36'(m_ovr) * 32 + 36'(m_done) * 16 + 36'(m_en) * 8 + 36'(m_lvl);
      t_datai = 36'(m_counter());
      e_rack  = t_rd & t_hit;
      e_wack  = t_wr & t_hit;
      e_nxd   = t_req & ~t_hit;
      e_rdata = e_rack ? (bus.cond ? t_coni : t_datai) : 36'd0;
      t_old_done = m_done;
      t_expire   = 1'b0;
      if (t_first && t_wr && t_hit && !bus.cond) begin
        m_interval = bus.write_data[17:0];
        m_run      = 0;
      end else if (m_en && m_interval != 18'd0) begin
        m_run++;
        t_expire = (m_run % PRESCALE == 0) && ((m_run / PRESCALE) % m_interval == 0);
      end
      if (t_first && t_wr && t_hit && bus.cond) begin
        m_en  = bus.write_data[3];
        m_lvl = bus.write_data[2:0];
        if (bus.write_data[4]) begin m_done = 0; m_ovr = 0; end
      end
      if (t_expire) begin
        if (t_old_done) m_ovr = 1;
        m_done = 1;
      end
      m_seen = t_req;
      e_pi = (m_done && m_lvl != 3'd0) ? 7'(7'b1000000 >> (m_lvl - 3'd1)) : 7'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_read_ack",  bus.read_ack,  e_rack);
      check("model_write_ack", bus.write_ack, e_wack);
      check("model_nxd",       bus.nxd,       e_nxd);
      check("model_read_data", bus.read_data, e_rdata);
      check("model_pi",        bus.pi,        e_pi);
    end
  end

  // Call at a negedge; returns at a negedge one idle cycle after the response.
  task automatic xfer(input logic wr, input logic cond, input logic [6:0] dev,
                      input logic [35:0] data, output logic [35:0] rdata, output logic nxd);
    bit got = 0;
    rdata = '0;
    nxd   = 1'b0;
    #1;
    bus.dev = dev; bus.cond = cond; bus.write_data = data;
    bus.read = !wr; bus.write = wr;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.read_ack || bus.write_ack || bus.nxd) begin
        got = 1; rdata = bus.read_data; nxd = bus.nxd;
      end
    end
    check("xfer_response", 36'(got), 36'd1);
    #1;
    bus.read = 1'b0; bus.write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [35:0] rd;
  logic        nx;

  initial begin
    reset = 1'b1;
    bus.dev = '0; bus.cond = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.write_data = '0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    check("reset_read_ack",  bus.read_ack,  0);
    check("reset_write_ack", bus.write_ack, 0);
    check("reset_nxd",       bus.nxd,       0);
    check("reset_pi",        bus.pi,        0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Non-matching device answers with nxd only, and leaves the status untouched.
    xfer(1'b0, 1'b1, 7'o021, 36'd0, rd, nx);
    check("nxd_flag", nx, 1);
    check("nxd_data", rd, 0);
    xfer(1'b0, 1'b1, DEV, 36'd0, rd, nx);
    check("coni_after_nxd", rd, 36'o0);

    // Basic expiry: interval 5, four clocks per tick, PI level 5.
    xfer(1'b1, 1'b0, DEV, 36'd5, rd, nx);
    xfer(1'b1, 1'b1, DEV, 36'o15, rd, nx);
    repeat (18) @(negedge clk);
    check("pi_before_expiry", bus.pi, 0);
    @(negedge clk);
    check("pi_at_expiry", bus.pi, 7'b0000100);
    xfer(1'b0, 1'b0, DEV, 36'd0, rd, nx);
    check("datai_after_expiry", rd, 36'd5);

    // Second expiry without a clear sets OVERRUN.
    repeat (18) @(negedge clk);
    xfer(1'b0, 1'b1, DEV, 36'd0, rd, nx);
    check("coni_overrun", rd, 36'o000000000075);

    // CLEAR_DONE landing on the third expiry loses; a later clear takes effect.
    repeat (17) @(negedge clk);
    xfer(1'b1, 1'b1, DEV, 36'o35, rd, nx);
    check("pi_clear_vs_expiry", bus.pi, 7'b0000100);
    xfer(1'b1, 1'b1, DEV, 36'o35, rd, nx);
    check("pi_after_clear", bus.pi, 0);
    xfer(1'b0, 1'b1, DEV, 36'd0, rd, nx);
    check("coni_after_clear", rd, 36'o15);

    // Held DATAO 3 for ten cycles: one load, counting continues while held.
    #1;
    bus.dev = DEV; bus.cond = 1'b0; bus.write_data = 36'd3; bus.write = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("held_ack_%0d", i), bus.write_ack, 1);
    end
    #1 bus.write = 1'b0;
    @(negedge clk);
    check("held_ack_drop", bus.write_ack, 0);
    xfer(1'b0, 1'b0, DEV, 36'd0, rd, nx);
    check("held_single_load", rd, 36'd1);

    // Interval 0 halts counting even when enabled.
    xfer(1'b1, 1'b1, DEV, 36'o25, rd, nx);
    xfer(1'b1, 1'b0, DEV, 36'd0, rd, nx);
    xfer(1'b1, 1'b1, DEV, 36'o15, rd, nx);
    repeat (20) @(negedge clk);
    check("zero_interval_pi", bus.pi, 0);
    xfer(1'b0, 1'b0, DEV, 36'd0, rd, nx);
    check("zero_interval_datai", rd, 36'd0);

    // Disable freezes prescaler and counter; re-enable resumes from the frozen phase.
    xfer(1'b1, 1'b0, DEV, 36'd2, rd, nx);
    repeat (3) @(negedge clk);
    xfer(1'b1, 1'b1, DEV, 36'o05, rd, nx);
    xfer(1'b0, 1'b0, DEV, 36'd0, rd, nx);
    check("frozen_datai", rd, 36'd1);
    repeat (8) @(negedge clk);
    xfer(1'b1, 1'b1, DEV, 36'o15, rd, nx);
    @(negedge clk);
    check("resume_pi_before", bus.pi, 0);
    @(negedge clk);
    check("resume_pi_expiry", bus.pi, 7'b0000100);

    // Reset in the middle of an acked DATAI; the held read is then served afresh.
    #1;
    bus.dev = DEV; bus.cond = 1'b0; bus.read = 1'b1;
    @(negedge clk);
    check("rst_read_ack_before", bus.read_ack, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_read_ack",  bus.read_ack,  0);
    check("rst_mid_read_data", bus.read_data, 0);
    check("rst_mid_pi",        bus.pi,        0);
    check("rst_mid_nxd",       bus.nxd,       0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_fresh_ack",  bus.read_ack,  1);
    check("rst_fresh_data", bus.read_data, 0);
    #1 bus.read = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
